// File: rtl/vigna.sv
// vigna: multi-cycle RV32I core (FETCH -> EXEC -> optional MEM), one instruction at a time.
// Separate instruction and data buses, each with a registered valid/ready handshake.
module vigna #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        i_valid,
  input  logic        i_ready,
  output logic [31:0] i_addr,
  input  logic [31:0] i_rdata,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_addr,
  input  logic [31:0] d_rdata,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_wstrb
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM} state_e;

  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6f;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_OPIMM = 7'h13;
  localparam logic [6:0] OPC_OP    = 7'h33;

  state_e      state_q;
  logic [31:0] pc_q, ir_q;
  logic        i_valid_q, d_valid_q;
  logic [31:0] d_addr_q, d_wdata_q;
  logic [3:0]  d_wstrb_q;
  logic [1:0]  lo_q;
  logic [31:0] rf [31:0];

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2, shamt;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, op_b, alu, sra_r, pc4, ea;
  logic [31:0] wb_d, npc, ld_v, ld_sh, st_wd;
  logic [15:0] ld_h;
  logic [3:0]  st_strb;
  logic        wb_en, taken, is_mem, rf_we, d_fire;

  assign opc   = ir_q[6:0];
  assign rd    = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1   = ir_q[19:15];
  assign rs2   = ir_q[24:20];
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
  assign op_b  = (opc == OPC_OP) ? rs2_v : imm_i;
  assign shamt = op_b[4:0];
  // Kept in its own assignment so the arithmetic shift is not demoted by an unsigned context.
  assign sra_r = $signed(rs1_v) >>> shamt;
  assign pc4   = pc_q + 32'd4;
  assign is_mem = (opc == OPC_LOAD) || (opc == OPC_STORE);
  assign ea    = rs1_v + ((opc == OPC_STORE) ? imm_s : imm_i);

  always_comb begin
    alu = 32'd0;
    case (f3)
      3'd0: alu = (opc == OPC_OP && ir_q[30]) ? rs1_v - op_b : rs1_v + op_b;
      3'd1: alu = rs1_v << shamt;
      3'd2: alu = {31'd0, $signed(rs1_v) < $signed(op_b)};
      3'd3: alu = {31'd0, rs1_v < op_b};
      3'd4: alu = rs1_v ^ op_b;
      3'd5: alu = ir_q[30] ? sra_r : rs1_v >> shamt;
      3'd6: alu = rs1_v | op_b;
      default: alu = rs1_v & op_b;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'd0: taken = rs1_v == rs2_v;
      3'd1: taken = rs1_v != rs2_v;
      3'd4: taken = $signed(rs1_v) < $signed(rs2_v);
      3'd5: taken = $signed(rs1_v) >= $signed(rs2_v);
      3'd6: taken = rs1_v < rs2_v;
      3'd7: taken = rs1_v >= rs2_v;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_en = 1'b0;
    wb_d  = alu;
    npc   = pc4;
    case (opc)
      OPC_LUI:   begin wb_en = 1'b1; wb_d = imm_u; end
      OPC_AUIPC: begin wb_en = 1'b1; wb_d = pc_q + imm_u; end
      OPC_JAL:   begin wb_en = 1'b1; wb_d = pc4; npc = pc_q + imm_j; end
      OPC_JALR:  begin wb_en = 1'b1; wb_d = pc4; npc = (rs1_v + imm_i) & ~32'd1; end
      OPC_BR:    npc = taken ? pc_q + imm_b : pc4;
      OPC_OPIMM, OPC_OP: wb_en = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    st_wd   = rs2_v;
    st_strb = 4'b1111;
    case (f3[1:0])
      2'd0: begin st_wd = {4{rs2_v[7:0]}};  st_strb = 4'b0001 << ea[1:0]; end
      2'd1: begin st_wd = {2{rs2_v[15:0]}}; st_strb = 4'b0011 << {ea[1], 1'b0}; end
      default: ;
    endcase
    if (opc == OPC_LOAD) begin
      st_wd   = 32'd0;
      st_strb = 4'b0000;
    end
  end

  assign ld_sh = d_rdata >> {lo_q, 3'b000};
  assign ld_h  = lo_q[1] ? d_rdata[31:16] : d_rdata[15:0];
  always_comb begin
    case (f3)
      3'd0: ld_v = {{24{ld_sh[7]}}, ld_sh[7:0]};
      3'd1: ld_v = {{16{ld_h[15]}}, ld_h};
      3'd4: ld_v = {24'd0, ld_sh[7:0]};
      3'd5: ld_v = {16'd0, ld_h};
      default: ld_v = d_rdata;
    endcase
  end

  assign d_fire = (state_q == S_MEM) && d_valid_q && d_ready;
  assign rf_we  = ((state_q == S_EXEC) && wb_en && !is_mem) || (d_fire && opc == OPC_LOAD);

  // Register file is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rf_we && rd != 5'd0) rf[rd] <= (state_q == S_MEM) ? ld_v : wb_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_ADDR;
      ir_q      <= 32'd0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      d_addr_q  <= 32'd0;
      d_wdata_q <= 32'd0;
      d_wstrb_q <= 4'd0;
      lo_q      <= 2'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          // A ready seen while valid is still low is stale and must not complete a fetch.
          if (!i_valid_q) i_valid_q <= 1'b1;
          else if (i_ready) begin
            i_valid_q <= 1'b0;
            ir_q      <= i_rdata;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_mem) begin
            d_addr_q  <= {ea[31:2], 2'b00};
            lo_q      <= ea[1:0];
            d_wdata_q <= st_wd;
            d_wstrb_q <= st_strb;
            state_q   <= S_MEM;
          end else begin
            pc_q    <= npc;
            state_q <= S_FETCH;
          end
        end
        S_MEM: begin
          if (!d_valid_q) d_valid_q <= 1'b1;
          else if (d_ready) begin
            d_valid_q <= 1'b0;
            d_wstrb_q <= 4'd0;
            pc_q      <= pc4;
            state_q   <= S_FETCH;
          end
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign i_valid = i_valid_q;
  assign i_addr  = pc_q;
  assign d_valid = d_valid_q;
  assign d_addr  = d_addr_q;
  assign d_wdata = d_wdata_q;
  assign d_wstrb = d_wstrb_q;
endmodule

// File: tb/tb_vigna.sv
// Bench for vigna: small programs run from a bench memory; expected stores are queued
// as each program is built and compared as the core writes them out.
module tb_vigna;
  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        i_valid, i_ready, d_valid, d_ready;
  logic [31:0] i_addr, i_rdata, d_addr, d_rdata, d_wdata;
  logic [3:0]  d_wstrb;

  vigna #(.RESET_ADDR(32'h0)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_rdata(d_rdata),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } st_t;
  st_t         sb[$];
  logic [31:0] prog[$];
  logic [31:0] ftrace[$];
  int          ftime[$];
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int          nchk = 0, nerr = 0, cyc = 0, i_stall = 0, d_stall = 0;
  logic        i_seen, d_seen, i_stale, d_stale;

  assign i_rdata = imem[i_addr[9:2]];
  assign d_rdata = dmem[d_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] es(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction
  function automatic logic [31:0] er(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] eu(input int imm, input int rd, input int op);
    logic [31:0] v = imm;
    return {v[19:0], 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] ej(input int imm, input int rd);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs, input int imm);
    return ei(imm, rs, 0, rd, 7'h13);
  endfunction
  function automatic logic [31:0] sw(input int rs2, input int off, input int rs1);
    return es(off, rs2, rs1, 2);
  endfunction

  task automatic p(input logic [31:0] w);
    prog.push_back(w);
  endtask
  task automatic exp_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_t e;
    e.addr = a; e.data = d; e.strb = s;
    sb.push_back(e);
  endtask

  task automatic start();
    resetn = 1'b0;
    i_stall = 0; d_stall = 0;
    repeat (2) @(negedge clk);
    foreach (imem[k]) imem[k] = 32'h0000_006f;
    foreach (prog[k]) imem[k] = prog[k];
    ftrace.delete(); ftime.delete();
    resetn = 1'b1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      chk({name, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    prog.delete();
  endtask

  initial forever begin @(posedge clk); cyc++; end

  // Zero-wait responder: ready one cycle after valid, held one extra (stale) cycle after each transfer.
  initial begin : resp
    logic nx;
    st_t  e;
    i_ready = 1'b0; d_ready = 1'b0;
    i_seen = 1'b0; d_seen = 1'b0; i_stale = 1'b0; d_stale = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        i_ready = 1'b0; d_ready = 1'b0;
        i_seen = 1'b0; d_seen = 1'b0; i_stale = 1'b0; d_stale = 1'b0;
      end else begin
        nx = (i_valid && i_seen && i_stall == 0) || (i_ready && !i_valid && !i_stale);
        i_stale = i_ready && !i_valid;
        i_seen = i_valid;
        if (i_valid && i_stall > 0) i_stall--;
        i_ready = nx;
        nx = (d_valid && d_seen && d_stall == 0) || (d_ready && !d_valid && !d_stale);
        d_stale = d_ready && !d_valid;
        d_seen = d_valid;
        if (d_valid && d_stall > 0) d_stall--;
        d_ready = nx;
        chk("excl", {31'd0, i_valid & d_valid}, 32'd0);
        if (i_valid && i_ready) begin ftrace.push_back(i_addr); ftime.push_back(cyc); end
        if (d_valid && d_ready && d_wstrb != 4'd0) begin
          for (int b = 0; b < 4; b++)
            if (d_wstrb[b]) dmem[d_addr[9:2]][8*b +: 8] = d_wdata[8*b +: 8];
          if (sb.size() == 0) chk("extra_store", d_addr, 32'hFFFF_FFFF);
          else begin
            e = sb.pop_front();
            chk("st_addr", d_addr, e.addr);
            chk("st_data", d_wdata, e.data);
            chk("st_strb", {28'd0, d_wstrb}, {28'd0, e.strb});
          end
        end
      end
    end
  end

  initial begin : main
    int n;
    foreach (dmem[k]) dmem[k] = 32'd0;
    foreach (imem[k]) imem[k] = 32'h0000_006f;
    #2 resetn = 1'b0;
    #1;
    chk("rst_ivalid", {31'd0, i_valid}, 0);
    chk("rst_dvalid", {31'd0, d_valid}, 0);
    chk("rst_wstrb", {28'd0, d_wstrb}, 0);
    chk("rst_daddr", d_addr, 0);
    chk("rst_wdata", d_wdata, 0);
    chk("rst_iaddr", i_addr, 0);

    // Arithmetic, compares, and latency
    p(addi(1, 0, 10)); p(addi(2, 0, 5));
    p(er(0, 2, 1, 0, 3)); p(er(32, 2, 1, 0, 4)); p(er(0, 2, 1, 7, 5));
    p(er(0, 2, 1, 6, 6)); p(er(0, 2, 1, 4, 7));
    p(sw(3, 'h40, 0)); p(sw(4, 'h44, 0)); p(sw(5, 'h48, 0)); p(sw(6, 'h4C, 0)); p(sw(7, 'h50, 0));
    p(addi(9, 0, -1)); p(er(0, 1, 9, 2, 10)); p(er(0, 1, 9, 3, 11));
    p(sw(10, 'h54, 0)); p(sw(11, 'h58, 0));
    exp_st('h40, 15, 4'hF); exp_st('h44, 5, 4'hF); exp_st('h48, 0, 4'hF);
    exp_st('h4C, 15, 4'hF); exp_st('h50, 15, 4'hF); exp_st('h54, 1, 4'hF); exp_st('h58, 0, 4'hF);
    start();
    @(posedge clk); #1 chk("ival_first_edge", {31'd0, i_valid}, 1);
    drain("arith");
    chk("lat_alu", ftime[1] - ftime[0], 4);
    chk("lat_store", ftime[8] - ftime[7], 7);

    // Shifts, with the first fetch stalled for 5 cycles
    p(addi(1, 0, 8)); p(ei(1, 1, 1, 2, 7'h13)); p(ei(1, 1, 5, 3, 7'h13));
    p(addi(4, 0, -8)); p(ei('h401, 4, 5, 5, 7'h13)); p(ei(1, 4, 5, 6, 7'h13)); p(er(32, 1, 4, 5, 7));
    p(sw(2, 'h80, 0)); p(sw(3, 'h84, 0)); p(sw(5, 'h88, 0)); p(sw(6, 'h8C, 0)); p(sw(7, 'h90, 0));
    exp_st('h80, 16, 4'hF); exp_st('h84, 4, 4'hF); exp_st('h88, 32'hFFFF_FFFC, 4'hF);
    exp_st('h8C, 32'h7FFF_FFFC, 4'hF); exp_st('h90, 32'hFFFF_FFFF, 4'hF);
    start();
    i_stall = 5;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("stall_ivalid", {31'd0, i_valid}, 1);
      chk("stall_iaddr", i_addr, 0);
      chk("stall_nofetch", ftrace.size(), 0);
    end
    drain("shift");

    // Loads and stores, all widths and lanes
    p(addi(1, 0, 100)); p(addi(2, 0, 'h678)); p(sw(2, 0, 1));
    p(ei(0, 1, 2, 3, 7'h03)); p(sw(3, 4, 1));
    p(addi(4, 0, 'h12)); p(es(1, 4, 1, 0));
    p(addi(5, 0, -128)); p(es(2, 5, 1, 1));
    p(ei(3, 1, 0, 6, 7'h03)); p(ei(1, 1, 4, 7, 7'h03)); p(ei(2, 1, 1, 8, 7'h03));
    p(ei(2, 1, 5, 9, 7'h03)); p(ei(2, 1, 2, 10, 7'h03));
    p(sw(6, 8, 1)); p(sw(7, 12, 1)); p(sw(8, 16, 1)); p(sw(9, 20, 1)); p(sw(10, 24, 1));
    exp_st(100, 'h678, 4'hF); exp_st(104, 'h678, 4'hF);
    exp_st(100, 32'h1212_1212, 4'b0010); exp_st(100, 32'hFF80_FF80, 4'b1100);
    exp_st(108, 32'hFFFF_FFFF, 4'hF); exp_st(112, 32'h12, 4'hF); exp_st(116, 32'hFFFF_FF80, 4'hF);
    exp_st(120, 32'h0000_FF80, 4'hF); exp_st(124, 32'hFF80_1278, 4'hF);
    start(); drain("ldst");

    // Branches: clear x3, then BEQ taken, then BNE not taken plus signed/unsigned compares
    p(addi(3, 0, 0)); p(sw(3, 'h60, 0)); exp_st('h60, 0, 4'hF);
    start(); drain("clr");
    p(addi(1, 0, 10)); p(addi(2, 0, 10)); p(eb(8, 2, 1, 0)); p(addi(3, 0, 1)); p(addi(4, 0, 1));
    p(sw(3, 'h60, 0)); p(sw(4, 'h64, 0));
    exp_st('h60, 0, 4'hF); exp_st('h64, 1, 4'hF);
    start(); drain("beq");
    p(addi(1, 0, 10)); p(addi(2, 0, 10)); p(eb(8, 2, 1, 1)); p(addi(3, 0, 1)); p(addi(4, 0, 1));
    p(sw(3, 'h60, 0)); p(sw(4, 'h64, 0));
    p(addi(5, 0, -1)); p(eb(8, 1, 5, 4)); p(addi(4, 0, 2)); p(eb(8, 1, 5, 7)); p(addi(4, 0, 3));
    p(sw(4, 'h68, 0));
    exp_st('h60, 1, 4'hF); exp_st('h64, 1, 4'hF); exp_st('h68, 1, 4'hF);
    start(); drain("bne");

    // Upper immediates, JAL link, unknown opcode as NOP
    p(eu('h12345, 1, 7'h37)); p(addi(1, 1, 'h678)); p(eu('h1000, 2, 7'h17));
    p(sw(1, 'h70, 0)); p(sw(2, 'h74, 0)); p(ej(8, 3)); p(sw(0, 'h7C, 0)); p(sw(3, 'h78, 0));
    p(32'h0000_01FF); p(sw(3, 'h7C, 0));
    exp_st('h70, 32'h1234_5678, 4'hF); exp_st('h74, 32'h0100_0008, 4'hF);
    exp_st('h78, 24, 4'hF); exp_st('h7C, 24, 4'hF);
    start(); drain("upper");

    // Reset asserted while a load is waiting in MEM
    p(addi(1, 0, 100)); p(ei(0, 1, 2, 2, 7'h03));
    start();
    d_stall = 1000;
    n = 0;
    while (!d_valid && n < 200) begin @(negedge clk); n++; end
    chk("mem_dvalid", {31'd0, d_valid}, 1);
    chk("mem_daddr", d_addr, 100);
    chk("mem_ld_strb", {28'd0, d_wstrb}, 0);
    @(posedge clk); #2 resetn = 1'b0; #1;
    chk("midrst_dvalid", {31'd0, d_valid}, 0);
    chk("midrst_ivalid", {31'd0, i_valid}, 0);
    chk("midrst_iaddr", i_addr, 0);
    d_stall = 0;
    @(negedge clk); resetn = 1'b1;
    @(posedge clk); #1;
    chk("restart_ivalid", {31'd0, i_valid}, 1);
    chk("restart_iaddr", i_addr, 0);
    prog.delete();

    // JALR to -4 and PC wrap back to 0
    p(addi(5, 0, 'h55)); p(ei(-4, 0, 0, 0, 7'h67));
    exp_st('h20, 'h55, 4'hF);
    start();
    imem[255] = sw(5, 'h20, 0);
    drain("jalr");
    chk("jalr_target", (ftrace.size() > 2) ? ftrace[2] : 32'h0, 32'hFFFF_FFFC);
    repeat (6) @(negedge clk);
    chk("pc_wrap", (ftrace.size() > 3) ? ftrace[3] : 32'h1, 32'h0);
    resetn = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
